// File: rtl/tdm_dmux_ctrl.sv
// tdm_dmux_ctrl
// Time-division controller for a 1:8 bit demultiplexer. A serial bit stream
// arrives under a valid/ready handshake. Each accepted bit is steered into the
// one-entry holding register of the current slot, and the slot then advances
// to the next enabled channel. Each holding register drains through its own
// valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   sync       frame start strobe; realigns the slot to the lowest enabled channel
//   in_bit     serial data bit
//   in_valid   in_bit valid
//   in_ready   controller accepts in_bit this cycle
//   en_mask    channel enable mask (bit k = 1 -> slot k used)
//   y          per-channel held bit
//   y_valid    per-channel holding register full
//   y_ready    per-channel consumer accept
//   sel        current slot / demux select
//   frame_cnt  completed frames, wraps modulo 2^CW
//   locked     high while the controller is running
module tdm_dmux_ctrl #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sync,
   input  logic          in_bit,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    en_mask,
   output logic [7:0]    y,
   output logic [7:0]    y_valid,
   input  logic [7:0]    y_ready,
   output logic [2:0]    sel,
   output logic [CW-1:0] frame_cnt,
   output logic          locked
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [2:0]    sel_q, sel_d;
   logic [7:0]    y_q, y_d;
   logic [7:0]    yv_q, yv_d;
   logic [CW-1:0] fcnt_q, fcnt_d;
   logic          accept;
   logic [2:0]    nxt_sel;

   // Lowest set index of the mask (0 when the mask is empty).
   function automatic logic [2:0] first_idx(input logic [7:0] m);
      logic [2:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) r = 3'(i);
      end
      return r;
   endfunction

   // Lowest set index above s, wrapping to the first enabled channel.
   function automatic logic [2:0] next_idx(input logic [7:0] m, input logic [2:0] s);
      logic [2:0] r;
      r = first_idx(m);
      for (int i = 7; i >= 0; i--) begin
         if (m[i] && (3'(i) > s)) r = 3'(i);
      end
      return r;
   endfunction

   // A full register that drains in the same cycle does not stall the stream.
   assign in_ready = ~rst & (state_q == RUN) & ~sync & en_mask[sel_q]
                     & (~yv_q[sel_q] | y_ready[sel_q]);
   assign accept   = in_valid & in_ready;
   assign nxt_sel  = next_idx(en_mask, sel_q);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      y_d     = y_q;
      fcnt_d  = fcnt_q;
      // Drains happen in every state; a load into the same channel overrides.
      yv_d    = yv_q & ~y_ready;

      case (state_q)
         IDLE: begin
            if (sync && (en_mask != 8'h00)) begin
               state_d = RUN;
               sel_d   = first_idx(en_mask);
            end
         end
         RUN: begin
            if (en_mask == 8'h00) begin
               state_d = IDLE;
            end else if (sync) begin
               sel_d = first_idx(en_mask);
            end else if (!en_mask[sel_q]) begin
               // Current slot was disabled mid-frame: skip it without a frame tick.
               sel_d = nxt_sel;
            end else if (accept) begin
               y_d[sel_q]  = in_bit;
               yv_d[sel_q] = 1'b1;
               sel_d       = nxt_sel;
               // Wrapping back (or staying on a single channel) closes a frame.
               if (nxt_sel <= sel_q) fcnt_d = fcnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         y_q     <= '0;
         yv_q    <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         y_q     <= y_d;
         yv_q    <= yv_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign y         = y_q;
   assign y_valid   = yv_q;
   assign sel       = sel_q;
   assign frame_cnt = fcnt_q;
   assign locked    = (state_q == RUN);

endmodule

// File: tb/tb_tdm_dmux_ctrl.sv
module tb_tdm_dmux_ctrl;

   logic       clk;
   logic       rst;
   logic       sync;
   logic       in_bit;
   logic       in_valid;
   logic [7:0] en_mask;
   logic [7:0] y_ready;

   logic       rdy8, rdy2;
   logic [7:0] y8, y2, yv8, yv2;
   logic [2:0] sel8, sel2;
   logic [7:0] fc8;
   logic [1:0] fc2;
   logic       lk8, lk2;

   int vectors;
   int miscompares;

   logic [7:0] bits;

   tdm_dmux_ctrl #(.CW(8)) dut8 (
      .clk(clk), .rst(rst), .sync(sync), .in_bit(in_bit), .in_valid(in_valid),
      .in_ready(rdy8), .en_mask(en_mask), .y(y8), .y_valid(yv8), .y_ready(y_ready),
      .sel(sel8), .frame_cnt(fc8), .locked(lk8)
   );

   tdm_dmux_ctrl #(.CW(2)) dut2 (
      .clk(clk), .rst(rst), .sync(sync), .in_bit(in_bit), .in_valid(in_valid),
      .in_ready(rdy2), .en_mask(en_mask), .y(y2), .y_valid(yv2), .y_ready(y_ready),
      .sel(sel2), .frame_cnt(fc2), .locked(lk2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and land 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; sync = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic do_sync(input logic [7:0] m);
      en_mask = m;
      sync = 1'b1;
      tick();
      sync = 1'b0;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1; sync = 1'b0; in_bit = 1'b0; in_valid = 1'b0;
      en_mask = 8'h00; y_ready = 8'h00;

      // ---- Reset state ----
      do_reset();
      rst = 1'b1; in_valid = 1'b1; en_mask = 8'hFF; #1;
      chk("rst_in_ready", {31'b0, rdy8}, 32'd0);
      in_valid = 1'b0; rst = 1'b0;
      chk("rst_sel", {29'b0, sel8}, 32'd0);
      chk("rst_y", {24'b0, y8}, 32'd0);
      chk("rst_yv", {24'b0, yv8}, 32'd0);
      chk("rst_fc", {24'b0, fc8}, 32'd0);
      chk("rst_locked", {31'b0, lk8}, 32'd0);
      chk("idle_in_ready", {31'b0, rdy8}, 32'd0);

      // ---- Test 1: all channels, stream 1,0,1,1,0,0,1,0 ----
      y_ready = 8'hFF;
      do_sync(8'hFF);
      chk("t1_locked", {31'b0, lk8}, 32'd1);
      bits = 8'b01001101;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_bit = bits[i];
         #1;
         chk($sformatf("t1_sel%0d", i), {29'b0, sel8}, i);
         chk($sformatf("t1_rdy%0d", i), {31'b0, rdy8}, 32'd1);
         tick();
      end
      in_valid = 1'b0;
      chk("t1_y", {24'b0, y8}, 32'h4D);
      chk("t1_yv", {24'b0, yv8}, 32'h80);
      chk("t1_fc", {24'b0, fc8}, 32'd1);
      chk("t1_sel_wrap", {29'b0, sel8}, 32'd0);
      tick();
      chk("t1_hold_sel", {29'b0, sel8}, 32'd0);
      chk("t1_hold_fc", {24'b0, fc8}, 32'd1);

      // ---- Test 2: sparse mask 1010_0100 ----
      do_reset();
      y_ready = 8'hFF;
      do_sync(8'hA4);
      in_valid = 1'b1; in_bit = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("t2_sel%0d", i), {29'b0, sel8}, (i % 3 == 0) ? 2 : (i % 3 == 1) ? 5 : 7);
         tick();
         chk($sformatf("t2_unused%0d", i), {24'b0, yv8 & 8'h5B}, 32'd0);
      end
      in_valid = 1'b0;
      chk("t2_fc", {24'b0, fc8}, 32'd2);
      chk("t2_sel_end", {29'b0, sel8}, 32'd2);

      // ---- Test 3: backpressure ----
      do_reset();
      y_ready = 8'h00;
      do_sync(8'hFF);
      bits = 8'b10010110;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_bit = bits[i];
         tick();
      end
      chk("t3_yv_full", {24'b0, yv8}, 32'hFF);
      chk("t3_y", {24'b0, y8}, 32'h96);
      chk("t3_fc", {24'b0, fc8}, 32'd1);
      in_bit = 1'b1; #1;
      chk("t3_stall_rdy", {31'b0, rdy8}, 32'd0);
      tick();
      chk("t3_stall_sel", {29'b0, sel8}, 32'd0);
      y_ready = 8'h01; #1;
      chk("t3_drain_rdy", {31'b0, rdy8}, 32'd1);
      tick();
      chk("t3_sel_after", {29'b0, sel8}, 32'd1);
      chk("t3_y_after", {24'b0, y8}, 32'h97);
      chk("t3_yv_after", {24'b0, yv8}, 32'hFF);
      chk("t3_rdy_ch1", {31'b0, rdy8}, 32'd0);
      tick();
      chk("t3_one_accept", {29'b0, sel8}, 32'd1);
      chk("t3_ch0_drained", {24'b0, yv8}, 32'hFE);
      in_valid = 1'b0; y_ready = 8'h00;

      // ---- Test 4: mid-frame sync and mid-frame mask change ----
      do_reset();
      y_ready = 8'hFF;
      do_sync(8'hFF);
      in_valid = 1'b1; in_bit = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("t4_sel4", {29'b0, sel8}, 32'd4);
      sync = 1'b1; #1;
      chk("t4_sync_rdy", {31'b0, rdy8}, 32'd0);
      tick();
      sync = 1'b0;
      chk("t4_sync_sel", {29'b0, sel8}, 32'd0);
      chk("t4_sync_fc", {24'b0, fc8}, 32'd0);
      chk("t4_sync_yv", {24'b0, yv8}, 32'd0);
      en_mask = 8'hF0; #1;
      chk("t4_skip_rdy", {31'b0, rdy8}, 32'd0);
      tick();
      chk("t4_skip_sel", {29'b0, sel8}, 32'd4);
      chk("t4_skip_fc", {24'b0, fc8}, 32'd0);
      chk("t4_skip_yv", {24'b0, yv8}, 32'd0);
      in_valid = 1'b0;

      // ---- Test 5: mask cleared while running ----
      do_reset();
      y_ready = 8'h00;
      do_sync(8'hFF);
      in_valid = 1'b1; in_bit = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("t5_sel3", {29'b0, sel8}, 32'd3);
      en_mask = 8'h00; #1;
      chk("t5_rdy_clr", {31'b0, rdy8}, 32'd0);
      tick();
      chk("t5_locked", {31'b0, lk8}, 32'd0);
      chk("t5_sel_held", {29'b0, sel8}, 32'd3);
      chk("t5_yv_kept", {24'b0, yv8}, 32'h07);
      chk("t5_idle_rdy", {31'b0, rdy8}, 32'd0);
      y_ready = 8'hFF;
      tick();
      chk("t5_drained", {24'b0, yv8}, 32'h00);
      chk("t5_y_kept", {24'b0, y8}, 32'h07);
      in_valid = 1'b0; y_ready = 8'h00;

      // ---- Test 6: CW=2 single channel, wrap, then reset mid-stream ----
      do_reset();
      y_ready = 8'hFF;
      do_sync(8'h01);
      in_valid = 1'b1; in_bit = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t6_fc%0d", i), {30'b0, fc2}, (i + 1) % 4);
         chk($sformatf("t6_sel%0d", i), {29'b0, sel2}, 32'd0);
      end
      chk("t6_y_pre", {24'b0, y2}, 32'h01);
      rst = 1'b1; #1;
      chk("t6_rst_rdy", {31'b0, rdy2}, 32'd0);
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("t6_rst_y", {24'b0, y2}, 32'd0);
      chk("t6_rst_yv", {24'b0, yv2}, 32'd0);
      chk("t6_rst_fc", {30'b0, fc2}, 32'd0);
      chk("t6_rst_sel", {29'b0, sel2}, 32'd0);
      chk("t6_rst_locked", {31'b0, lk2}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tdm_dmux_ctrl.md
Name: tdm_dmux_ctrl

Overview:
Time-division controller for the 1:8 bit demultiplexer path. Accepts a serial bit stream under valid/ready handshake and generates the 3-bit slot select. Steers each bit into a per-channel one-entry holding register with its own valid/ready handshake. Handles frame sync, channel skip masking, backpressure and frame counting.

Parameters:
CW, 8, width of frame counter frame_cnt (wraps modulo 2^CW)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
sync  input  1  frame start strobe; (re)aligns slot to lowest enabled channel
in_bit  input  1  serial data bit
in_valid  input  1  in_bit valid
in_ready  output  1  controller accepts in_bit this cycle
en_mask  input  8  channel enable; bit k=1 -> slot k used, 0 -> skipped
y  output  8  per-channel held bit (y[k] = channel k)
y_valid  output  8  per-channel holding register full
y_ready  input  8  per-channel consumer accept
sel  output  3  current slot / demux select
frame_cnt  output  CW  completed frames
locked  output  1  1 while in RUN

Behaviour:
- Reset (rst=1 at clk edge, overrides everything): state=IDLE, sel=0, y=0, y_valid=0, frame_cnt=0, locked=0; in_ready=0 while rst=1.
- "first(m)" = lowest set index of mask m; "next(m,s)" = lowest set index > s, else first(m) (wrap).
- IDLE: in_ready=0. If sync=1 and en_mask!=0 -> RUN next cycle, sel<=first(en_mask), locked<=1. sync with en_mask=0 ignored.
- RUN, in_ready (combinational) = ~sync & en_mask[sel] & (~y_valid[sel] | y_ready[sel]). A full register draining in the same cycle does not stall.
- accept = in_valid & in_ready. On accept: y[sel]<=in_bit, y_valid[sel]<=1, sel<=next(en_mask,sel). If next(en_mask,sel) <= sel (wrap, including single enabled channel), frame_cnt<=frame_cnt+1 (modulo 2^CW).
- Per channel k: if y_valid[k] & y_ready[k] and not loaded this cycle -> y_valid[k]<=0, y[k] unchanged. Load and drain in same cycle -> y_valid[k] stays 1 with new bit.
- y_ready[k] with y_valid[k]=0: no effect.
- sync=1 in RUN: no accept that cycle; sel<=first(en_mask); frame_cnt unchanged; held data/valids untouched.
- en_mask[sel]=0 in RUN (mask changed mid-frame): no accept; sel<=next(en_mask,sel) next cycle; no frame_cnt increment.
- en_mask=0 in RUN: -> IDLE next cycle, locked<=0, sel held, y/y_valid retained and still drainable.
- in_valid=0: sel and frame_cnt hold.
- Latency: accepted bit visible on y[k]/y_valid[k] one cycle after the accept edge. Throughput 1 bit/cycle when unblocked.

Test Plan:
1. rst; en_mask=FF, sync pulse, y_ready=FF, stream 8 bits 1,0,1,1,0,0,1,0 -> sel 0..7 in turn, y=8'b01001101 after 8th, frame_cnt=1, sel back to 0.
2. en_mask=8'b1010_0100, sync, 6 accepts -> sel sequence 2,5,7,2,5,7; frame_cnt=2; y_valid bits 0,1,3,4,6 never set.
3. y_ready=0, en_mask=FF, 8 accepts, then in_valid held -> in_ready=0 at sel=0; raise y_ready[0] only -> exactly one accept same cycle, y_valid[0] stays 1.
4. Mid-frame sync at sel=4 -> in_ready=0 that cycle, next sel=0, frame_cnt unchanged.
5. RUN with sel=3, clear en_mask to 0 -> locked=0 next cycle, in_ready=0, y_valid preserved; drain via y_ready clears them.
6. CW=2, single channel en_mask=8'h01, 5 accepts -> frame_cnt 1,2,3,0,1; rst mid-stream -> all outputs zero next cycle.
